// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// the default operand width.
package serial_adder_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full-adder cell built from two half adders plus an OR for carry.
// Purely combinational; the serial controller time-multiplexes one instance.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  logic partial_sum;
  logic partial_carry;
  logic second_carry;

  half_adder u_ha_ab (
    .a     (a),
    .b     (b),
    .sum   (partial_sum),
    .carry (partial_carry)
  );

  half_adder u_ha_cin (
    .a     (partial_sum),
    .b     (carry_in),
    .sum   (sum),
    .carry (second_carry)
  );

  assign carry_out = partial_carry | second_carry;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell processes one bit
// per clock across a WIDTH-bit operand pair, with start/busy/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` input for a-b mode.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned IDX_W = $clog2(WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_bit;
  logic             sub_mode;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_shifted;
  logic             carry;
  logic             cell_sum;
  logic             cell_carry;
  logic [IDX_W-1:0] idx;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_mode = sub;
`else
  assign sub_mode = 1'b0;
`endif

  assign last_bit = (idx == LAST_IDX);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  serial_fa_cell u_cell (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .carry_in  (carry),
    .sum       (cell_sum),
    .carry_out (cell_carry)
  );

  // Next-state logic and start acceptance (only in IDLE or DONE).
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // New sum bit enters at the MSB while earlier bits move toward the LSB;
  // written as shift-then-overwrite so WIDTH=1 needs no special case.
  always_comb begin
    sum_shifted            = sum >> 1;
    sum_shifted[WIDTH-1]   = cell_sum;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Operand capture on acceptance, one bit processed per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr      <= '0;
      b_sr      <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      carry_out <= 1'b0;
      idx       <= '0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= sub_mode ? ~b : b;
      carry <= sub_mode;
      idx   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      sum   <= sum_shifted;
      carry <= cell_carry;
      idx   <= idx + IDX_W'(1);
      if (last_bit) carry_out <= cell_carry;
    end
  end

endmodule
